// File: rtl/operand_stager.sv
// Operand stager: gathers two operand bytes (A then B) from a valid/ready stream,
// holds them stable for the adder until acknowledged, and counts delivered pairs.
module operand_stager #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ack,
  output logic [CNT_W-1:0] pair_count
);

  typedef enum logic [1:0] {
    WAIT_A,
    WAIT_B,
    PRESENT
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   load_a;
  logic   load_b;
  logic   count_en;

  // in_ready includes rst_n so the producer sees no acceptance while in reset
  assign in_ready = (state != PRESENT) && !clear && rst_n;
  assign op_valid = (state == PRESENT);

  always_comb begin
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    count_en  = 1'b0;
    if (clear) begin
      state_nxt = WAIT_A;
    end else begin
      case (state)
        WAIT_A: begin
          if (in_valid && in_ready) begin
            load_a    = 1'b1;
            state_nxt = WAIT_B;
          end
        end
        WAIT_B: begin
          if (in_valid && in_ready) begin
            load_b    = 1'b1;
            state_nxt = PRESENT;
          end
        end
        PRESENT: begin
          if (op_ack) begin
            count_en  = 1'b1;
            state_nxt = WAIT_A;
          end
        end
        default: state_nxt = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else if (clear) begin
      op_a <= '0;
      op_b <= '0;
    end else begin
      if (load_a) op_a <= in_data;
      if (load_b) op_b <= in_data;
    end
  end

  // clear suppresses count_en in the decode above, so the counter needs no clear term
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_count <= '0;
    end else if (count_en) begin
      pair_count <= pair_count + CNT_W'(1);
    end
  end

endmodule
